// File: rtl/mips_defs.sv
// Shared definitions for the interrupt sequencer:
// FSM state encoding and default vector layout.
package mips_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAKE  = 2'd1,
    SERVE = 2'd2
  } irq_state_e;

  localparam int          N_IRQ_DEF      = 3;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

endpackage

// File: rtl/irq_sequencer_if.sv
// Core-side bundle of the interrupt sequencer:
// request/mask/stall/PC inputs and PC redirect outputs.
interface irq_sequencer_if
  import mips_defs::*;
#(
  parameter int N_IRQ = N_IRQ_DEF
);
  logic [N_IRQ-1:0] IrqIn;
  logic             MaskWe;
  logic [N_IRQ-1:0] MaskData;
  logic             Stall;
  logic [31:0]      PcNext;
  logic             Eret;
  logic             IrqTake;
  logic [31:0]      IrqVector;
  logic             EretTake;
  logic [31:0]      EpcOut;
  logic             IrqActive;
  logic [1:0]       IrqId;
  logic [N_IRQ-1:0] Pending;
  logic [N_IRQ-1:0] Mask;

  modport master (
    output IrqIn, MaskWe, MaskData,
    output Stall, PcNext, Eret,
    input  IrqTake, IrqVector,
    input  EretTake, EpcOut,
    input  IrqActive, IrqId,
    input  Pending, Mask
  );

  modport slave (
    input  IrqIn, MaskWe, MaskData,
    input  Stall, PcNext, Eret,
    output IrqTake, IrqVector,
    output EretTake, EpcOut,
    output IrqActive, IrqId,
    output Pending, Mask
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// o_valid is 1 when any request bit is set.
module irq_prio_enc #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [1:0]   o_id
);
  always_comb begin
    o_id = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = i[1:0];
    end
  end

  assign o_valid = |i_req;
endmodule

// File: rtl/irq_sequencer.sv
// Priority interrupt sequencer: edge-latched requests,
// fixed-priority take, EPC save and ERET return.
module irq_sequencer
  import mips_defs::*;
#(
  parameter int          N_IRQ      = N_IRQ_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input logic            clk,
  input logic            rst,
  irq_sequencer_if.slave bus
);
  irq_state_e       r_state;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_mask;
  logic [1:0]       r_id;
  logic [31:0]      r_epc;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_clr;
  logic             w_valid;
  logic [1:0]       w_win;

  assign w_rise = bus.IrqIn & ~r_prev;
  assign w_elig = r_pend & ~r_mask;
  assign w_clr  = (r_state == TAKE) ?
                  (N_IRQ'(1) << r_id) : '0;

  irq_prio_enc #(
    .N (N_IRQ)
  ) u_enc (
    .i_req   (w_elig),
    .o_valid (w_valid),
    .o_id    (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_id    <= 2'd0;
      r_epc   <= 32'd0;
    end else begin
      r_prev <= bus.IrqIn;
      // a fresh edge wins over the clear of the source being taken
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (bus.MaskWe) r_mask <= bus.MaskData;
      unique case (r_state)
        IDLE: begin
          if (w_valid && !bus.Stall) begin
            r_state <= TAKE;
            r_id    <= w_win;
          end
        end
        TAKE: begin
          r_epc   <= bus.PcNext;
          r_state <= SERVE;
        end
        SERVE: begin
          if (bus.Eret) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.IrqTake   = (r_state == TAKE);
  assign bus.IrqVector = VEC_BASE + 32'(r_id) * VEC_STRIDE;
  assign bus.EretTake  = (r_state == SERVE) && bus.Eret;
  assign bus.EpcOut    = r_epc;
  assign bus.IrqActive = (r_state == SERVE);
  assign bus.IrqId     = r_id;
  assign bus.Pending   = r_pend;
  assign bus.Mask      = r_mask;
endmodule
